// File: rtl/instr_mem_stream_loader.sv
// Run-time instruction memory loader: accepts words from a valid/ready stream and
// writes them one byte per cycle from BASE_ADDR, holding the CPU until the image is complete.
module instr_mem_stream_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_BYTES = 4,
  parameter int BASE_ADDR  = 0,
  parameter int SWAP_BYTES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     word_count,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*WORD_BYTES-1:0] in_data,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [7:0]              mem_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    cpu_hold,
  output logic [ADDR_WIDTH:0]     words_loaded
);

  localparam int LW = $clog2(WORD_BYTES + 1);
  localparam int DW = 8 * WORD_BYTES;
  localparam logic [ADDR_WIDTH+1:0] MEM_BYTES = {2'b01, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH+1:0] WB_EXT    = (ADDR_WIDTH+2)'(WORD_BYTES);
  localparam logic [ADDR_WIDTH:0]   BASE_EXT  = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [LW-1:0]         LAST_LANE = LW'(WORD_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_ERROR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [DW-1:0]         data_q, data_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [7:0]            wdata_q, wdata_d;

  logic [ADDR_WIDTH+1:0] next_addr;
  logic [ADDR_WIDTH:0]   words_inc;

  function automatic logic [7:0] byte_sel(input logic [DW-1:0] d, input logic [LW-1:0] lane);
    int k;
    k = (SWAP_BYTES != 0) ? (WORD_BYTES - 1 - int'(lane)) : int'(lane);
    return d[8*k +: 8];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      words_q <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Byte outputs are registered one cycle ahead so lane 0 appears the cycle after the handshake
  // and address/data hold their last value once the write burst ends.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    words_d   = words_q;
    lane_d    = lane_q;
    data_d    = data_q;
    we_d      = 1'b0;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    next_addr = {1'b0, addr_q} + WB_EXT;
    words_inc = words_q + (ADDR_WIDTH+1)'(1);

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          words_d = '0;
          if (word_count == '0) begin
            state_d = S_DONE;
          end else begin
            count_d = word_count;
            addr_d  = BASE_EXT;
            state_d = S_ACCEPT;
          end
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          data_d  = in_data;
          we_d    = 1'b1;
          maddr_d = addr_q[ADDR_WIDTH-1:0];
          wdata_d = byte_sel(in_data, '0);
          lane_d  = LW'(1);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (lane_q != LAST_LANE) begin
          we_d    = 1'b1;
          maddr_d = addr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(lane_q);
          wdata_d = byte_sel(data_q, lane_q);
          lane_d  = lane_q + LW'(1);
        end else begin
          // Final byte is on the bus this cycle; decide where the session goes next.
          words_d = words_inc;
          addr_d  = next_addr[ADDR_WIDTH:0];
          if (words_inc == count_q) begin
            state_d = S_DONE;
          end else if (next_addr + WB_EXT > MEM_BYTES) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_ACCEPT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready     = (state_q == S_ACCEPT);
  assign busy         = (state_q == S_ACCEPT) || (state_q == S_WRITE);
  assign done         = (state_q == S_DONE);
  assign overflow     = (state_q == S_ERROR);
  assign cpu_hold     = (state_q != S_DONE);
  assign mem_we       = we_q;
  assign mem_addr     = maddr_q;
  assign mem_wdata    = wdata_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_mem_stream_loader.sv
// Bench for instr_mem_stream_loader: four instances (default, 16-byte memory, byte-swapped,
// base 8) share the stream inputs; each has its own start. Writes are checked against a scoreboard.
module tb_instr_mem_stream_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        start_v [4];

  logic        in_ready_w [4];
  logic        mem_we_w   [4];
  logic        busy_w     [4];
  logic        done_w     [4];
  logic        ovf_w      [4];
  logic        hold_w     [4];
  logic [11:0] mem_addr_w [4];
  logic [7:0]  mem_wdata_w[4];
  logic [12:0] words_w    [4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int AW = (gi == 1) ? 4 : 12;
    localparam int BA = (gi == 3) ? 8 : 0;
    localparam int SW = (gi == 2) ? 1 : 0;
    logic [AW:0]   wc;
    logic [AW-1:0] ma;
    logic [AW:0]   wl;
    assign wc = word_count[AW:0];
    instr_mem_stream_loader #(.ADDR_WIDTH(AW), .WORD_BYTES(4), .BASE_ADDR(BA), .SWAP_BYTES(SW)) u_dut (
      .clk(clk), .rst(rst), .start(start_v[gi]), .word_count(wc),
      .in_valid(in_valid), .in_ready(in_ready_w[gi]), .in_data(in_data),
      .mem_we(mem_we_w[gi]), .mem_addr(ma), .mem_wdata(mem_wdata_w[gi]),
      .busy(busy_w[gi]), .done(done_w[gi]), .overflow(ovf_w[gi]),
      .cpu_hold(hold_w[gi]), .words_loaded(wl)
    );
    assign mem_addr_w[gi] = 12'(ma);
    assign words_w[gi]    = 13'(wl);
  end

  typedef struct {int d; logic [11:0] addr; logic [7:0] data;} exp_t;
  exp_t       sb[$];
  logic [7:0] mem_m [4][4096];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model and scoreboard consumer: every byte write must match the next expected entry.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we_w[i] === 1'b1) begin
        exp_t e;
        e = (sb.size() > 0) ? sb.pop_front() : '{-1, 12'h0, 8'h0};
        chk("wr_dut", i, e.d);
        chk("wr_addr", mem_addr_w[i], e.addr);
        chk("wr_data", mem_wdata_w[i], e.data);
        mem_m[i][mem_addr_w[i]] = mem_wdata_w[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int d, input logic [31:0] w, input int lane);
    logic [31:0] t;
    t = (d == 2) ? (w >> (8 * (3 - lane))) : (w >> (8 * lane));
    return t[7:0];
  endfunction

  task automatic push_word(input int d, input int base, input logic [31:0] w);
    exp_t e;
    for (int l = 0; l < 4; l++) begin
      e.d = d; e.addr = 12'(base + l); e.data = exp_byte(d, w, l);
      sb.push_back(e);
    end
  endtask

  task automatic start_session(input int d, input int cnt);
    word_count = 13'(cnt);
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
  endtask

  task automatic send_word(input int d, input int base, input logic [31:0] w,
                           input bit keep, input bit start_last);
    int n;
    push_word(d, base, w);
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (in_ready_w[d] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("accept_wait", (n < 40), 1'b1);
    if (n >= 40) begin
      in_valid = 1'b0;
      return;
    end
    tick();
    if (!keep) in_valid = 1'b0;
    for (int l = 0; l < 4; l++) begin
      chk("we_in_write", mem_we_w[d], 1'b1);
      chk("ready_in_write", in_ready_w[d], 1'b0);
      if (start_last && l == 3) begin
        word_count = 13'd3;
        start_v[d] = 1'b1;
      end
      tick();
      start_v[d] = 1'b0;
    end
    chk("we_after_word", mem_we_w[d], 1'b0);
    $display("word dut=%0d base=%0h data=%08h words_loaded=%0d", d, base, w, words_w[d]);
  endtask

  task automatic chk_img(input int d, input int base, input logic [31:0] w);
    for (int l = 0; l < 4; l++) chk("image", mem_m[d][base + l], exp_byte(d, w, l));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      for (int a = 0; a < 4096; a++) mem_m[i][a] = 8'h00;
    end
    tick();
    tick();
    // Reset state
    chk("rst_in_ready", in_ready_w[0], 1'b0);
    chk("rst_mem_we", mem_we_w[0], 1'b0);
    chk("rst_mem_addr", mem_addr_w[0], 12'h0);
    chk("rst_mem_wdata", mem_wdata_w[0], 8'h0);
    chk("rst_busy", busy_w[0], 1'b0);
    chk("rst_done", done_w[0], 1'b0);
    chk("rst_overflow", ovf_w[0], 1'b0);
    chk("rst_cpu_hold", hold_w[0], 1'b1);
    chk("rst_words", words_w[0], 13'd0);
    rst = 1'b0;
    tick();

    // 1: two words back to back; start during the final byte is ignored
    start_session(0, 2);
    chk("s1_busy", busy_w[0], 1'b1);
    send_word(0, 0, 32'h00500093, 1'b1, 1'b0);
    chk("s1_mid_ready", in_ready_w[0], 1'b1);
    send_word(0, 4, 32'h00100113, 1'b1, 1'b1);
    in_valid = 1'b0;
    chk("s1_done", done_w[0], 1'b1);
    chk("s1_words", words_w[0], 13'd2);
    chk("s1_cpu_hold", hold_w[0], 1'b0);
    chk("s1_busy_done", busy_w[0], 1'b0);
    chk("s1_ready_done", in_ready_w[0], 1'b0);
    chk_img(0, 0, 32'h00500093);
    chk_img(0, 4, 32'h00100113);

    // 2: backpressure gap between words
    for (int a = 0; a < 8; a++) mem_m[0][a] = 8'h00;
    start_session(0, 2);
    chk("s2_done_clr", done_w[0], 1'b0);
    chk("s2_hold", hold_w[0], 1'b1);
    chk("s2_words_clr", words_w[0], 13'd0);
    send_word(0, 0, 32'h00500093, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      chk("s2_gap_we", mem_we_w[0], 1'b0);
      chk("s2_gap_ready", in_ready_w[0], 1'b1);
      tick();
    end
    send_word(0, 4, 32'h00100113, 1'b0, 1'b0);
    chk("s2_done", done_w[0], 1'b1);
    chk("s2_words", words_w[0], 13'd2);
    chk_img(0, 0, 32'h00500093);
    chk_img(0, 4, 32'h00100113);

    // 3: overflow in a 16-byte memory, then recovery
    start_session(1, 5);
    for (int k = 0; k < 4; k++) send_word(1, 4 * k, 32'hA0B0C0D0 + 32'(k), 1'b0, 1'b0);
    chk("s3_overflow", ovf_w[1], 1'b1);
    chk("s3_done", done_w[1], 1'b0);
    chk("s3_ready", in_ready_w[1], 1'b0);
    chk("s3_hold", hold_w[1], 1'b1);
    chk("s3_words", words_w[1], 13'd4);
    chk_img(1, 12, 32'hA0B0C0D3);
    start_session(1, 1);
    chk("s3_ovf_clr", ovf_w[1], 1'b0);
    send_word(1, 0, 32'h0BADF00D, 1'b0, 1'b0);
    chk("s3_done2", done_w[1], 1'b1);
    chk("s3_words2", words_w[1], 13'd1);
    chk_img(1, 0, 32'h0BADF00D);

    // 4: byte order
    start_session(2, 1);
    send_word(2, 0, 32'h11223344, 1'b0, 1'b0);
    chk("s4_swap_b0", mem_m[2][0], 8'h11);
    chk("s4_swap_b3", mem_m[2][3], 8'h44);
    start_session(0, 1);
    send_word(0, 0, 32'h11223344, 1'b0, 1'b0);
    chk("s4_le_b0", mem_m[0][0], 8'h44);
    chk("s4_le_b3", mem_m[0][3], 8'h11);

    // 5: zero-length image, then non-zero base address
    chk("s5_idle_done", done_w[3], 1'b0);
    start_session(3, 0);
    chk("s5_done", done_w[3], 1'b1);
    chk("s5_hold", hold_w[3], 1'b0);
    chk("s5_words", words_w[3], 13'd0);
    chk("s5_we", mem_we_w[3], 1'b0);
    start_session(3, 1);
    send_word(3, 8, 32'hCAFEBABE, 1'b0, 1'b0);
    chk("s5_base_done", done_w[3], 1'b1);
    chk_img(3, 8, 32'hCAFEBABE);

    // 6a: asynchronous reset during lane 2
    start_session(0, 2);
    push_word(0, 0, 32'hAABBCCDD);
    in_data  = 32'hAABBCCDD;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("s6_lane2_we", mem_we_w[0], 1'b1);
    chk("s6_lane2_addr", mem_addr_w[0], 12'h2);
    #1 rst = 1'b1;
    #1;
    chk("s6_async_we", mem_we_w[0], 1'b0);
    chk("s6_async_busy", busy_w[0], 1'b0);
    chk("s6_async_ready", in_ready_w[0], 1'b0);
    chk("s6_async_hold", hold_w[0], 1'b1);
    chk("s6_pending", sb.size(), 2);
    sb.delete();
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int g = 0; g < 3; g++) begin
      chk("s6_idle_ready", in_ready_w[0], 1'b0);
      tick();
    end
    in_valid = 1'b0;

    // 6b: start during ACCEPT has no effect
    start_session(0, 2);
    tick();
    word_count = 13'd1;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    chk("s6_accept_ready", in_ready_w[0], 1'b1);
    send_word(0, 0, 32'h01020304, 1'b0, 1'b0);
    chk("s6_not_done", done_w[0], 1'b0);
    chk("s6_words1", words_w[0], 13'd1);
    send_word(0, 4, 32'h05060708, 1'b0, 1'b0);
    chk("s6_done", done_w[0], 1'b1);
    chk("s6_words2", words_w[0], 13'd2);

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_stream_loader.md
Name: instr_mem_stream_loader

Overview:
Run-time loader that fills the byte-addressed instruction memory from a word stream (UART bridge or testbench driver). It replaces the elaboration-time file preload. Each accepted word is split into bytes and written one byte per cycle, little-endian by default, starting at a base address. The CPU is held off until a complete image has been written, and overflow of the memory is flagged.

Parameters:
ADDR_WIDTH, 12, byte-address width; memory depth is 2**ADDR_WIDTH bytes
WORD_BYTES, 4, bytes per input word; in_data width is 8*WORD_BYTES
BASE_ADDR, 0, first byte address written; must be a multiple of WORD_BYTES and below 2**ADDR_WIDTH
SWAP_BYTES, 0, 0 stores LSB at the lowest address (little-endian); 1 stores MSB at the lowest address

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a load session (honoured only in IDLE, DONE or ERROR)
word_count  in  ADDR_WIDTH+1  number of words to load; latched on an accepted start
in_valid  in  1  in_data is valid
in_ready  out  1  loader accepts a word this cycle
in_data  in  8*WORD_BYTES  instruction word
mem_we  out  1  byte write enable to instruction memory
mem_addr  out  ADDR_WIDTH  byte address
mem_wdata  out  8  byte data
busy  out  1  session in progress (ACCEPT or WRITE)
done  out  1  image complete; held until the next start or reset
overflow  out  1  sticky error; held until the next start or reset
cpu_hold  out  1  keeps the CPU in reset; 0 only in DONE
words_loaded  out  ADDR_WIDTH+1  count of words fully written in this session

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, overflow=0, cpu_hold=1, words_loaded=0, state=IDLE.
- Reset is asynchronous: outputs take their reset values immediately, including during WRITE. Memory contents already written are left as they are.
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE: cpu_hold=1.
  - start with word_count=0 -> DONE on the next cycle; no writes.
  - start with word_count>0 -> latch the count, set addr=BASE_ADDR, clear words_loaded/done/overflow, go to ACCEPT.
- ACCEPT: in_ready=1, busy=1. A handshake (in_valid & in_ready) in cycle N latches in_data, sets lane=0, and moves to WRITE. in_data is ignored when in_valid=0.
- WRITE: in_ready=0, busy=1, mem_we=1 for exactly WORD_BYTES cycles (N+1 .. N+WORD_BYTES).
  - mem_addr = addr+lane.
  - mem_wdata = in_data[8*k+7:8*k], where k=lane if SWAP_BYTES=0, else k=WORD_BYTES-1-lane.
- After the last lane:
  - words_loaded += 1 and addr += WORD_BYTES.
  - If words_loaded equals the latched count -> DONE.
  - Else if addr+WORD_BYTES > 2**ADDR_WIDTH -> ERROR.
  - Else -> ACCEPT. in_ready is asserted again at cycle N+WORD_BYTES+1.
  - Maximum throughput is one word per WORD_BYTES+1 cycles.
- Address arithmetic uses ADDR_WIDTH+1 bits so the overflow compare never wraps. mem_addr never exceeds 2**ADDR_WIDTH-1.
- DONE: done=1, cpu_hold=0, busy=0, in_ready=0, mem_we=0. start begins a new session (done clears the next cycle, cpu_hold returns to 1).
- ERROR: overflow=1, cpu_hold=1, in_ready=0, mem_we=0. start begins a new session and clears overflow.
- start while busy is ignored. Edge case: start in the same cycle as the final byte is ignored, and the block still goes to DONE.
- mem_addr and mem_wdata hold their last values when mem_we=0. Consumers use mem_we only.
- words_loaded holds its value in DONE and ERROR.

Test Plan:
1. Reset, start with word_count=2, stream 0x00500093 then 0x00100113 with in_valid held high -> bytes at 0..7 are 93,00,50,00,13,01,10,00. mem_we is high in cycles N+1..N+4 for each word. done=1, words_loaded=2, cpu_hold falls to 0.
2. Backpressure: in_valid low for 3 cycles between words -> no mem_we during the gap. in_ready stays 1 in ACCEPT and is 0 throughout WRITE. Final image is identical to scenario 1.
3. Overflow with ADDR_WIDTH=4, word_count=5 -> 4 words fill addresses 0..15. Then overflow=1, done=0, in_ready=0, cpu_hold=1. A new start with word_count=1 clears overflow and writes addresses 0..3.
4. SWAP_BYTES=1, word 0x11223344 -> addresses 0..3 hold 11,22,33,44. With SWAP_BYTES=0 they hold 44,33,22,11.
5. start with word_count=0 -> done=1 one cycle later, no mem_we, words_loaded=0. Also BASE_ADDR=8, word_count=1 -> writes land at 8..11.
6. Assert rst asynchronously during lane 2 of a word -> mem_we, busy and in_ready drop before the next clock edge, cpu_hold=1, state IDLE. start pulsed during ACCEPT in a separate run -> no effect on the session.
